instr_fetch_mem: RTL and testbench

- Loadable instruction memory plus registered fetch stage, directly upstream of mips_processor.
- The bench or boot logic writes the program word-by-word in LOAD state, then asserts load_done.
- In RUN, it returns the instruction at the processor's byte-addressed pc_out with one-cycle latency.
- Replaces the bench-side array-indexed-by-PC and enforces word alignment and range checks.

---
 rtl/mips_pkg.sv | 12 +
 rtl/instr_fetch_mem_if.sv | 30 +++
 rtl/instr_ram.sv | 31 +++
 rtl/instr_fetch_mem.sv | 105 ++++++++++
 tb/tb_instr_fetch_mem.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-side types and constants: word width, NOP encoding and fetch FSM states.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    FETCH_LOAD = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_mem_if.sv
// Load/fetch bus between the boot loader/processor (master) and instr_fetch_mem (slave).
interface instr_fetch_mem_if #(
  parameter int unsigned ADDR_W = 6
);
  import mips_pkg::*;

  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               load_done;
  logic               reload;
  logic [31:0]        pc_in;
  logic               fetch_en;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               addr_err;
  logic               running;
  logic [31:0]        fetch_count;

  modport master (
    output load_en, load_addr, load_data, load_done, reload, pc_in, fetch_en,
    input  instr, instr_valid, addr_err, running, fetch_count
  );

  modport slave (
    input  load_en, load_addr, load_data, load_done, reload, pc_in, fetch_en,
    output instr, instr_valid, addr_err, running, fetch_count
  );

endinterface

// File: rtl/instr_ram.sv
// DEPTH x 32 instruction storage: one write port, one synchronous read port with read enable.
// Read data holds while i_re is low; contents are never reset.
module instr_ram #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [ADDR_W-1:0]            i_waddr,
  input  logic [mips_pkg::INSTR_W-1:0] i_wdata,
  input  logic                         i_re,
  input  logic [ADDR_W-1:0]            i_raddr,
  output logic [mips_pkg::INSTR_W-1:0] o_rdata
);
  import mips_pkg::*;

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory with registered fetch: LOAD writes words, RUN returns mem[pc>>2] one clk later.
// Optional FETCH_STATS_EN enables the fetch_count counter (tied to 0 otherwise).
module instr_fetch_mem #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned ADDR_W   = 6,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input logic              clk,
  input logic              rst_n,
  instr_fetch_mem_if.slave bus
);
  import mips_pkg::*;

  fetch_state_t       r_state;
  logic               r_running;
  logic               r_instr_valid;
  logic               r_addr_err;
  logic               r_sel_ram;
  logic [INSTR_W-1:0] w_ram_q;
  logic [ADDR_W-1:0]  w_idx;
  logic               w_misaligned;
  logic               w_out_of_range;
  logic               w_good;
  logic               w_fetch;
  logic               w_ram_we;
  logic               w_ram_re;

  assign w_misaligned   = |bus.pc_in[1:0];
  assign w_out_of_range = |bus.pc_in[31:ADDR_W+2];
  assign w_idx          = bus.pc_in[ADDR_W+1:2];
  assign w_good         = !w_misaligned && !w_out_of_range;
  assign w_fetch        = (r_state == FETCH_RUN) && bus.fetch_en && !bus.reload;
  assign w_ram_we       = (r_state == FETCH_LOAD) && bus.load_en;
  assign w_ram_re       = w_fetch && w_good;

  instr_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (bus.load_addr),
    .i_wdata (bus.load_data),
    .i_re    (w_ram_re),
    .i_raddr (w_idx),
    .o_rdata (w_ram_q)
  );

  // RAM read data only advances on good fetches, so r_sel_ram picks it or NOP and both hold together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FETCH_LOAD;
      r_running     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_addr_err    <= 1'b0;
      r_sel_ram     <= 1'b0;
    end else begin
      case (r_state)
        FETCH_LOAD: begin
          if (bus.load_done) begin
            r_state   <= FETCH_RUN;
            r_running <= 1'b1;
          end
        end
        FETCH_RUN: begin
          if (bus.reload) begin
            r_state       <= FETCH_LOAD;
            r_running     <= 1'b0;
            r_instr_valid <= 1'b0;
            r_addr_err    <= 1'b0;
            r_sel_ram     <= 1'b0;
          end else if (bus.fetch_en) begin
            r_instr_valid <= 1'b1;
            r_addr_err    <= !w_good;
            r_sel_ram     <= w_good;
          end
        end
      endcase
    end
  end

  assign bus.instr       = r_sel_ram ? w_ram_q : NOP_WORD;
  assign bus.instr_valid = r_instr_valid;
  assign bus.addr_err    = r_addr_err;
  assign bus.running     = r_running;

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if ((r_state == FETCH_RUN) && bus.reload) begin
      r_fetch_count <= '0;
    end else if (w_fetch) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign bus.fetch_count = r_fetch_count;
`else
  assign bus.fetch_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Randomized and directed bench for instr_fetch_mem against a word-array reference model.
module tb_instr_fetch_mem;

  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  instr_fetch_mem_if #(.ADDR_W(6)) bus();

  instr_fetch_mem #(.DEPTH(DEPTH), .ADDR_W(6), .NOP_WORD(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: program array plus the visible output state.
  logic [31:0] m_mem [DEPTH];
  bit          m_run;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_err;
  logic [31:0] m_cnt;

  function automatic logic [31:0] exp_cnt();
`ifdef FETCH_STATS_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_run = 0; m_instr = NOP; m_valid = 0; m_err = 0; m_cnt = 0;
  endtask

  // Drive inputs at negedge, advance one rising edge, update the model, sample 1ns later.
  task automatic step(input logic le, input logic [5:0] la, input logic [31:0] ld,
                      input logic done, input logic rl, input logic [31:0] pc, input logic fe);
    @(negedge clk);
    bus.load_en = le; bus.load_addr = la; bus.load_data = ld;
    bus.load_done = done; bus.reload = rl; bus.pc_in = pc; bus.fetch_en = fe;
    @(posedge clk);
    if (!m_run) begin
      if (le) m_mem[la] = ld;
      if (done) m_run = 1;
    end else if (rl) begin
      m_run = 0; m_instr = NOP; m_valid = 0; m_err = 0; m_cnt = 0;
    end else if (fe) begin
      m_cnt = m_cnt + 1;
      m_valid = 1;
      if ((pc % 4) != 0 || pc >= DEPTH * 4) begin
        m_instr = NOP; m_err = 1;
      end else begin
        m_instr = m_mem[pc / 4]; m_err = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0; bus.load_done = 0;
    bus.reload = 0; bus.pc_in = 0; bus.fetch_en = 0;
    model_reset();
    #12;
    checks++; if (bus.instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", bus.instr, NOP); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.addr_err); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", bus.running); end
    checks++; if (bus.fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.fetch_count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_and_fetch();
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] w;
      w = (i == 0) ? 32'h01098020 : (i == 1) ? 32'h014B8822 : (i == 2) ? 32'h018D9024 : $urandom;
      step(1, i[5:0], w, 0, 0, $urandom, $urandom_range(0, 1));
      checks++; if (bus.instr_valid !== 1'b0 || bus.running !== 1'b0) begin errors++; $display("FAIL load_outputs: valid=%b running=%b want 0 0", bus.instr_valid, bus.running); end
    end
    step(0, 0, 0, 1, 0, 0, 0);
    checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL enter_run: running=%b want 1", bus.running); end
    step(0, 0, 0, 0, 0, 32'd0, 1);
    checks++; if (bus.instr !== 32'h01098020) begin errors++; $display("FAIL fetch_pc0: instr=%h want 01098020", bus.instr); end
    checks++; if (bus.instr_valid !== 1'b1 || bus.addr_err !== 1'b0) begin errors++; $display("FAIL fetch_pc0_flags: valid=%b err=%b want 1 0", bus.instr_valid, bus.addr_err); end
    step(0, 0, 0, 0, 0, 32'd4, 1);
    checks++; if (bus.instr !== 32'h014B8822) begin errors++; $display("FAIL fetch_pc4: instr=%h want 014B8822", bus.instr); end
  endtask

  task automatic test_misaligned();
    step(0, 0, 0, 0, 0, 32'h6, 1);
    checks++; if (bus.instr !== NOP || bus.addr_err !== 1'b1 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL misaligned: instr=%h err=%b valid=%b want %h 1 1", bus.instr, bus.addr_err, bus.instr_valid, NOP); end
    step(0, 0, 0, 0, 0, 32'h8, 1);
    checks++; if (bus.instr !== 32'h018D9024 || bus.addr_err !== 1'b0) begin errors++; $display("FAIL after_misaligned: instr=%h err=%b want 018D9024 0", bus.instr, bus.addr_err); end
  endtask

  task automatic test_out_of_range();
    step(0, 0, 0, 0, 0, 32'h100, 1);
    checks++; if (bus.instr !== NOP || bus.addr_err !== 1'b1) begin errors++; $display("FAIL out_of_range: instr=%h err=%b want %h 1", bus.instr, bus.addr_err, NOP); end
    step(0, 0, 0, 0, 0, 32'h8000_0000, 1);
    checks++; if (bus.addr_err !== 1'b1) begin errors++; $display("FAIL out_of_range_msb: err=%b want 1", bus.addr_err); end
    step(0, 0, 0, 0, 0, 32'hFC, 1);
    checks++; if (bus.instr !== m_mem[63] || bus.addr_err !== 1'b0) begin errors++; $display("FAIL last_word: instr=%h err=%b want %h 0", bus.instr, bus.addr_err, m_mem[63]); end
  endtask

  task automatic test_hold_and_ignored_writes();
    logic [31:0] held;
    held = m_mem[63];
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, $urandom, 0);
      checks++; if (bus.instr !== held || bus.instr_valid !== 1'b1 || bus.addr_err !== 1'b0) begin errors++; $display("FAIL hold_%0d: instr=%h valid=%b err=%b want %h 1 0", i, bus.instr, bus.instr_valid, bus.addr_err, held); end
    end
    step(1, 6'd0, 32'hFFFFFFFF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 32'd0, 1);
    checks++; if (bus.instr !== 32'h01098020) begin errors++; $display("FAIL run_write_ignored: instr=%h want 01098020", bus.instr); end
  endtask

  task automatic test_reset_mid_run();
    step(0, 0, 0, 0, 0, 32'd8, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.instr !== NOP || bus.instr_valid !== 1'b0 || bus.running !== 1'b0) begin errors++; $display("FAIL async_reset: instr=%h valid=%b running=%b want %h 0 0", bus.instr, bus.instr_valid, bus.running, NOP); end
    checks++; if (bus.fetch_count !== 32'd0) begin errors++; $display("FAIL async_reset_count: got %0d want 0", bus.fetch_count); end
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 32'd4, 1);
    checks++; if (bus.instr !== 32'h014B8822 || bus.running !== 1'b1) begin errors++; $display("FAIL retained_mem: instr=%h running=%b want 014B8822 1", bus.instr, bus.running); end
  endtask

  task automatic test_reload_counter();
    logic [31:0] want5;
    step(0, 0, 0, 0, 1, 32'd0, 1);
    checks++; if (bus.running !== 1'b0 || bus.instr_valid !== 1'b0 || bus.fetch_count !== 32'd0) begin errors++; $display("FAIL reload: running=%b valid=%b count=%0d want 0 0 0", bus.running, bus.instr_valid, bus.fetch_count); end
    step(1, 6'd5, 32'hA5A50005, 1, 0, 0, 0);
    checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL load_and_done: running=%b want 1", bus.running); end
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 32'd4 * (i + 1), 1);
`ifdef FETCH_STATS_EN
    want5 = 32'd5;
`else
    want5 = 32'd0;
`endif
    checks++; if (bus.fetch_count !== want5) begin errors++; $display("FAIL count_5: got %0d want %0d", bus.fetch_count, want5); end
    checks++; if (bus.instr !== 32'hA5A50005) begin errors++; $display("FAIL load_and_done_word: instr=%h want a5a50005", bus.instr); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7) pc = {24'd0, $urandom_range(0, 63) * 4};
      else if (sel < 9) pc = {24'd0, 8'($urandom_range(0, 255))};
      else pc = $urandom;
      step($urandom_range(0, 1), 6'($urandom_range(0, 63)), $urandom,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0), pc, $urandom_range(0, 3) != 0);
      checks++; if (bus.instr !== m_instr) begin errors++; $display("FAIL rnd%0d_instr: got %h want %h", n, bus.instr, m_instr); end
      checks++; if (bus.instr_valid !== m_valid) begin errors++; $display("FAIL rnd%0d_valid: got %b want %b", n, bus.instr_valid, m_valid); end
      checks++; if (bus.addr_err !== m_err) begin errors++; $display("FAIL rnd%0d_err: got %b want %b", n, bus.addr_err, m_err); end
      checks++; if (bus.running !== m_run) begin errors++; $display("FAIL rnd%0d_running: got %b want %b", n, bus.running, m_run); end
      checks++; if (bus.fetch_count !== exp_cnt()) begin errors++; $display("FAIL rnd%0d_count: got %0d want %0d", n, bus.fetch_count, exp_cnt()); end
    end
  endtask

  initial begin
    test_reset();
    test_load_and_fetch();
    test_misaligned();
    test_out_of_range();
    test_hold_and_ignored_writes();
    test_reset_mid_run();
    test_reload_counter();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
